// File: rtl/tape_prefetch.sv
// tape_prefetch: prefetches a tape image from SDRAM into a small byte FIFO.
//   CLKSYS      system clock, rising edge
//   reset       synchronous active-high reset
//   rewind      pulse: flush the FIFO and restart fetching from byte 0
//   hold        level: block new SDRAM reads while an image download is active
//   file_size   image length in bytes
//   sdram_rd    one-cycle read request strobe
//   sdram_addr  even byte address of the requested word
//   sdram_data  returned word, low byte = even address
//   sdram_ready one-cycle strobe qualifying sdram_data
//   byte_req    consumer pop request
//   byte_out    FIFO head byte (first-word fall-through)
//   byte_valid  FIFO not empty
//   eof         whole image fetched and FIFO drained
//   underrun    sticky: pop requested on an empty FIFO
module tape_prefetch #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        CLKSYS,
    input  logic        reset,
    input  logic        rewind,
    input  logic        hold,
    input  logic [24:0] file_size,
    output logic        sdram_rd,
    output logic [24:0] sdram_addr,
    input  logic [15:0] sdram_data,
    input  logic        sdram_ready,
    input  logic        byte_req,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        eof,
    output logic        underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_wr_nxt;
    logic [AW:0]   r_count;
    // One spare bit so the address can step past a file_size near 2^25
    logic [25:0]   r_fetch_addr, w_size;
    logic [TW-1:0] r_tmo;
    logic          r_underrun;
    logic          w_tmo_hit, w_start, w_tail, w_accept, w_pop;
    logic [1:0]    w_push_n;

    assign w_size    = {1'b0, file_size};
    assign w_tmo_hit = r_tmo == TW'(TIMEOUT - 1);
    // A read is only launched when both bytes of the word are guaranteed to fit
    assign w_start   = !hold && r_fetch_addr < w_size && r_count <= (AW+1)'(DEPTH - 2);
    assign w_tail    = r_fetch_addr + 26'd1 >= w_size;
    assign w_accept  = r_state == S_WAIT && sdram_ready && !rewind;
    assign w_push_n  = !w_accept ? 2'd0 : w_tail ? 2'd1 : 2'd2;
    assign w_pop     = byte_req && r_count != '0 && !rewind;
    assign w_wr_nxt  = r_wr_ptr + 1'b1;

    always_ff @(posedge CLKSYS) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        sdram_rd = 1'b0;
        case (r_state)
            S_IDLE:  w_next = (!rewind && w_start) ? S_REQ : S_IDLE;
            S_REQ: begin
                sdram_rd = 1'b1;
                w_next   = rewind ? S_IDLE : S_WAIT;
            end
            // A rewind here leaves a response in flight; DRAIN swallows it
            S_WAIT:  w_next = rewind ? S_DRAIN : sdram_ready ? S_IDLE : w_tmo_hit ? S_REQ : S_WAIT;
            S_DRAIN: w_next = (sdram_ready || w_tmo_hit) ? S_IDLE : S_DRAIN;
        endcase
    end

    // Counts consecutive cycles spent in WAIT or DRAIN; cleared on any transition
    always_ff @(posedge CLKSYS) begin
        if (reset)
            r_tmo <= '0;
        else
            r_tmo <= (w_next == r_state && (r_state == S_WAIT || r_state == S_DRAIN)) ? r_tmo + 1'b1 : '0;
    end

    always_ff @(posedge CLKSYS) begin
        if (reset || rewind) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_fetch_addr <= '0;
            r_underrun   <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_push_n) - (AW+1)'(w_pop);
            if (w_accept)
                r_fetch_addr <= r_fetch_addr + 26'd2;
            if (byte_req && r_count == '0)
                r_underrun <= 1'b1;
        end
    end

    always_ff @(posedge CLKSYS) begin
        if (!reset && w_accept) begin
            r_mem[r_wr_ptr] <= sdram_data[7:0];
            if (!w_tail)
                r_mem[w_wr_nxt] <= sdram_data[15:8];
        end
    end

    assign sdram_addr = r_fetch_addr[24:0];
    assign byte_valid = r_count != '0;
    assign byte_out   = byte_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign underrun   = r_underrun;
    assign eof        = r_fetch_addr >= w_size && r_state == S_IDLE && r_count == '0;
endmodule

// File: tb/tb_tape_prefetch.sv
// tb_tape_prefetch: directed self-checking bench for tape_prefetch.
module tb_tape_prefetch;
    logic        CLKSYS = 1'b0;
    logic        reset, rewind, hold, sdram_rd, sdram_ready, byte_req, byte_valid, eof, underrun;
    logic [24:0] file_size, sdram_addr;
    logic [15:0] sdram_data;
    logic [7:0]  byte_out;

    int checks = 0;
    int errors = 0;
    int pend = 0;
    int drop = 0;
    int rd_cnt = 0;
    logic [24:0] pend_addr;
    logic [24:0] rd_log [64];
    logic [7:0]  got [16];
    logic [7:0]  exp_b [4];
    int ngot;

    always #5 CLKSYS = ~CLKSYS;

    tape_prefetch dut (
        .CLKSYS(CLKSYS), .reset(reset), .rewind(rewind), .hold(hold),
        .file_size(file_size), .sdram_rd(sdram_rd), .sdram_addr(sdram_addr),
        .sdram_data(sdram_data), .sdram_ready(sdram_ready), .byte_req(byte_req),
        .byte_out(byte_out), .byte_valid(byte_valid), .eof(eof), .underrun(underrun)
    );

    function automatic logic [15:0] mem_word(input logic [24:0] a);
        case (a)
            25'd0:   return 16'hBBAA;
            25'd2:   return 16'hDDCC;
            25'd6:   return 16'h1234;
            default: return {a[7:0] + 8'd1, a[7:0]};
        endcase
    endfunction

    // SDRAM model: answers each read 3 cycles later, optionally dropping answers
    initial begin
        sdram_ready = 1'b0;
        sdram_data  = 16'h0000;
        forever begin
            @(negedge CLKSYS);
            sdram_ready = 1'b0;
            if (reset) begin
                pend   = 0;
                rd_cnt = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        if (drop > 0)
                            drop--;
                        else begin
                            sdram_ready = 1'b1;
                            sdram_data  = mem_word(pend_addr);
                        end
                    end
                end
                if (sdram_rd) begin
                    pend      = 3;
                    pend_addr = sdram_addr;
                    if (rd_cnt < 64)
                        rd_log[rd_cnt] = sdram_addr;
                    rd_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic do_reset(input logic [24:0] fs);
        reset = 1'b1; rewind = 1'b0; hold = 1'b0; byte_req = 1'b0; file_size = fs; drop = 0;
        repeat (2) @(negedge CLKSYS);
        reset = 1'b0;
    endtask

    // Pops whenever a byte is visible, recording each popped head byte
    task automatic collect(input int want, input int maxc);
        ngot = 0;
        for (int c = 0; c < maxc && ngot < want; c++) begin
            @(negedge CLKSYS);
            if (byte_valid) begin
                got[ngot] = byte_out;
                ngot++;
                byte_req = 1'b1;
            end else
                byte_req = 1'b0;
        end
        @(negedge CLKSYS);
        byte_req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; rewind = 1'b0; hold = 1'b0; byte_req = 1'b0; file_size = 25'd0;
        repeat (2) @(negedge CLKSYS);
        checks++; if (sdram_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", sdram_rd); end
        checks++; if (sdram_addr !== 25'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", sdram_addr); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
        checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", byte_out); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        checks++; if (eof !== 1'b1) begin errors++; $display("FAIL reset_eof_empty: got %b want 1", eof); end
        file_size = 25'd4;
        #1;
        checks++; if (eof !== 1'b0) begin errors++; $display("FAIL reset_eof_size4: got %b want 0", eof); end
        file_size = 25'd0;
        @(negedge CLKSYS);
        reset = 1'b0;
        repeat (5) @(negedge CLKSYS);
        checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL zero_size_reads: got %0d want 0", rd_cnt); end
        checks++; if (eof !== 1'b1) begin errors++; $display("FAIL zero_size_eof: got %b want 1", eof); end
    endtask

    task automatic test_basic;
        do_reset(25'd4);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        checks++; if (eof !== 1'b0) begin errors++; $display("FAIL basic_eof_start: got %b want 0", eof); end
        collect(4, 80);
        checks++; if (ngot !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", ngot); end
        for (int i = 0; i < 4 && i < ngot; i++) begin
            checks++; if (got[i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        checks++; if (rd_cnt !== 2) begin errors++; $display("FAIL basic_reads: got %0d want 2", rd_cnt); end
        checks++; if (rd_log[0] !== 25'd0 || rd_log[1] !== 25'd2) begin errors++; $display("FAIL basic_addrs: got %0d,%0d want 0,2", rd_log[0], rd_log[1]); end
        checks++; if (eof !== 1'b1) begin errors++; $display("FAIL basic_eof: got %b want 1", eof); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_odd_tail;
        do_reset(25'd3);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC;
        collect(3, 80);
        repeat (10) @(negedge CLKSYS);
        checks++; if (ngot !== 3) begin errors++; $display("FAIL odd_count: got %0d want 3", ngot); end
        for (int i = 0; i < 3 && i < ngot; i++) begin
            checks++; if (got[i] !== exp_b[i]) begin errors++; $display("FAIL odd_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL odd_extra_byte: got valid %b want 0", byte_valid); end
        checks++; if (rd_cnt !== 2) begin errors++; $display("FAIL odd_reads: got %0d want 2", rd_cnt); end
        checks++; if (eof !== 1'b1) begin errors++; $display("FAIL odd_eof: got %b want 1", eof); end
    endtask

    task automatic test_full_fifo;
        logic seen;
        logic [24:0] a;
        do_reset(25'd64);
        repeat (40) @(negedge CLKSYS);
        checks++; if (rd_cnt !== 4) begin errors++; $display("FAIL full_reads: got %0d want 4", rd_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_log[i] !== 25'(2 * i)) begin errors++; $display("FAIL full_addr%0d: got %0d want %0d", i, rd_log[i], 2 * i); end
        end
        checks++; if (byte_out !== 8'hAA) begin errors++; $display("FAIL full_head: got %h want aa", byte_out); end
        byte_req = 1'b1;
        @(negedge CLKSYS);
        byte_req = 1'b0;
        checks++; if (byte_out !== 8'hBB) begin errors++; $display("FAIL full_pop1: got %h want bb", byte_out); end
        repeat (10) @(negedge CLKSYS);
        checks++; if (rd_cnt !== 4) begin errors++; $display("FAIL full_one_free: got %0d reads want 4", rd_cnt); end
        byte_req = 1'b1;
        @(negedge CLKSYS);
        byte_req = 1'b0;
        checks++; if (byte_out !== 8'hCC) begin errors++; $display("FAIL full_pop2: got %h want cc", byte_out); end
        seen = 1'b0; a = '0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge CLKSYS);
            if (sdram_rd) begin seen = 1'b1; a = sdram_addr; end
        end
        checks++; if (!seen || a !== 25'd8) begin errors++; $display("FAIL full_refill: seen %b addr %0d want 1 addr 8", seen, a); end
    endtask

    task automatic test_rewind_wait;
        logic seen;
        logic [24:0] a;
        do_reset(25'd64);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge CLKSYS);
            if (sdram_rd && sdram_addr == 25'd6) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rew_rd6: got no read at 6 want one"); end
        @(negedge CLKSYS);
        rewind = 1'b1;
        @(negedge CLKSYS);
        rewind = 1'b0;
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rew_flush: got valid %b want 0", byte_valid); end
        repeat (2) @(negedge CLKSYS);
        checks++; if (byte_valid !== 1'b0 || sdram_rd !== 1'b0) begin errors++; $display("FAIL rew_drain: got valid %b rd %b want 0 0", byte_valid, sdram_rd); end
        seen = 1'b0; a = '1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge CLKSYS);
            if (sdram_rd) begin seen = 1'b1; a = sdram_addr; end
        end
        checks++; if (!seen || a !== 25'd0) begin errors++; $display("FAIL rew_restart: seen %b addr %0d want 1 addr 0", seen, a); end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge CLKSYS);
            if (byte_valid) seen = 1'b1;
        end
        checks++; if (byte_out !== 8'hAA) begin errors++; $display("FAIL rew_first_byte: got %h want aa", byte_out); end
    endtask

    task automatic test_timeout;
        int nrd, c0, c1;
        logic [24:0] a1;
        logic vb;
        do_reset(25'd4);
        drop = 1;
        nrd = 0; c0 = 0; c1 = 0; a1 = '1; vb = 1'b1;
        for (int c = 0; c < 400 && nrd < 2; c++) begin
            @(negedge CLKSYS);
            if (sdram_rd) begin
                if (nrd == 0) c0 = c;
                else begin c1 = c; a1 = sdram_addr; vb = byte_valid; end
                nrd++;
            end
        end
        checks++; if (nrd !== 2) begin errors++; $display("FAIL tmo_reissue: got %0d reads want 2", nrd); end
        checks++; if (c1 - c0 !== 256) begin errors++; $display("FAIL tmo_gap: got %0d cycles want 256", c1 - c0); end
        checks++; if (a1 !== 25'd0) begin errors++; $display("FAIL tmo_addr: got %0d want 0", a1); end
        checks++; if (vb !== 1'b0) begin errors++; $display("FAIL tmo_nopush: got valid %b want 0", vb); end
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        collect(4, 80);
        checks++; if (ngot !== 4) begin errors++; $display("FAIL tmo_count: got %0d want 4", ngot); end
        for (int i = 0; i < 4 && i < ngot; i++) begin
            checks++; if (got[i] !== exp_b[i]) begin errors++; $display("FAIL tmo_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_underrun_hold;
        int nrd;
        do_reset(25'd0);
        @(negedge CLKSYS);
        byte_req = 1'b1;
        @(negedge CLKSYS);
        byte_req = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_set: got %b want 1", underrun); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL und_valid: got %b want 0", byte_valid); end
        repeat (3) @(negedge CLKSYS);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_sticky: got %b want 1", underrun); end
        hold = 1'b1;
        file_size = 25'd16;
        nrd = 0;
        repeat (20) begin
            @(negedge CLKSYS);
            if (sdram_rd) nrd++;
        end
        checks++; if (nrd !== 0) begin errors++; $display("FAIL hold_block: got %0d reads want 0", nrd); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_hold_sticky: got %b want 1", underrun); end
        hold = 1'b0;
        @(negedge CLKSYS);
        checks++; if (sdram_rd !== 1'b1 || sdram_addr !== 25'd0) begin errors++; $display("FAIL hold_resume: got rd %b addr %0d want 1 addr 0", sdram_rd, sdram_addr); end
        rewind = 1'b1;
        @(negedge CLKSYS);
        rewind = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL und_rewind: got %b want 0", underrun); end
        checks++; if (sdram_rd !== 1'b0) begin errors++; $display("FAIL rew_req_idle: got rd %b want 0", sdram_rd); end
    endtask

    initial begin
        reset = 1'b1; rewind = 1'b0; hold = 1'b0; byte_req = 1'b0; file_size = 25'd0;
        test_reset;
        test_basic;
        test_odd_tail;
        test_full_fifo;
        test_rewind_wait;
        test_timeout;
        test_underrun_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
